// File: rtl/grid_game_fsm.sv
// Room-grid adventure game: player walks a GRID_W x GRID_H map, picks up a sword, fights a dragon, exits to win.
// Optional move limit enabled by defining GAME_MOVE_LIMIT_EN.
module grid_game_fsm #(
    parameter int unsigned GRID_W      = 3,
    parameter int unsigned GRID_H      = 3,
    parameter int unsigned START_ROOM  = 0,
    parameter int unsigned SWORD_ROOM  = 2,
    parameter int unsigned DRAGON_ROOM = 4,
    parameter int unsigned EXIT_ROOM   = 8,
    parameter logic [GRID_W*GRID_H-1:0] BLOCK_MASK = '0,
    parameter int unsigned MAX_MOVES   = 8,
    localparam int unsigned ROOM_W = $clog2(GRID_W*GRID_H),
    localparam int unsigned MOVE_W = $clog2(MAX_MOVES+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n,
    input  logic              s,
    input  logic              e,
    input  logic              w,
    output logic [ROOM_W-1:0] room,
    output logic              sword,
    output logic              slain,
    output logic [MOVE_W-1:0] moves,
    output logic              win,
    output logic              d
);

    localparam int unsigned CELLS   = GRID_W * GRID_H;
    localparam int unsigned X_W     = $clog2(GRID_W);
    localparam int unsigned Y_W     = $clog2(GRID_H);
    localparam int unsigned START_X = START_ROOM % GRID_W;
    localparam int unsigned START_Y = START_ROOM / GRID_W;
    localparam logic [2**ROOM_W-1:0] MASK_EXT = (2**ROOM_W)'(BLOCK_MASK);

    typedef enum logic [1:0] {PLAY, WIN, DEAD} state_t;

    function automatic bit room_bad(input int unsigned r);
        return (r >= CELLS) ? 1'b1 : BLOCK_MASK[r % CELLS];
    endfunction

    // Elaboration-time map sanity checks
    if (room_bad(START_ROOM))   begin : g_bad_start  $error("START_ROOM out of range or blocked");  end
    if (room_bad(SWORD_ROOM))   begin : g_bad_sword  $error("SWORD_ROOM out of range or blocked");  end
    if (room_bad(DRAGON_ROOM))  begin : g_bad_dragon $error("DRAGON_ROOM out of range or blocked"); end
    if (room_bad(EXIT_ROOM))    begin : g_bad_exit   $error("EXIT_ROOM out of range or blocked");   end
    if (START_ROOM == DRAGON_ROOM) begin : g_start_dragon $error("START_ROOM equals DRAGON_ROOM"); end

    state_t            state;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;

    logic [X_W-1:0]    cand_x;
    logic [Y_W-1:0]    cand_y;
    logic [ROOM_W-1:0] cand_room;
    logic              step_ok;
    logic              accept;
    logic [MOVE_W-1:0] moves_inc;
    logic              at_sword;
    logic              at_dragon;
    logic              dragon_kills;
    logic              slain_next;
    logic              wins;
    logic              limit_hit;

    // Candidate neighbour room and the consequences of entering it
    always_comb begin
        cand_x  = x_q;
        cand_y  = y_q;
        step_ok = 1'b0;
        unique case ({n, s, e, w})
            4'b1000: if (y_q != '0) begin
                cand_y  = y_q - Y_W'(1);
                step_ok = 1'b1;
            end
            4'b0100: if (y_q != Y_W'(GRID_H - 1)) begin
                cand_y  = y_q + Y_W'(1);
                step_ok = 1'b1;
            end
            4'b0010: if (x_q != X_W'(GRID_W - 1)) begin
                cand_x  = x_q + X_W'(1);
                step_ok = 1'b1;
            end
            4'b0001: if (x_q != '0) begin
                cand_x  = x_q - X_W'(1);
                step_ok = 1'b1;
            end
            default: step_ok = 1'b0;
        endcase

        cand_room    = ROOM_W'(int'(cand_y) * GRID_W + int'(cand_x));
        accept       = (state == PLAY) && step_ok && !MASK_EXT[cand_room];
        moves_inc    = (moves == '1) ? moves : moves + MOVE_W'(1);
        at_sword     = (cand_room == ROOM_W'(SWORD_ROOM));
        at_dragon    = (cand_room == ROOM_W'(DRAGON_ROOM));
        dragon_kills = at_dragon && !sword;
        slain_next   = slain || (at_dragon && sword);
        wins         = (cand_room == ROOM_W'(EXIT_ROOM)) && slain_next;
`ifdef GAME_MOVE_LIMIT_EN
        limit_hit    = (moves_inc == MOVE_W'(MAX_MOVES));
`else
        limit_hit    = 1'b0;
`endif
    end

    // Game state and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PLAY;
            x_q   <= X_W'(START_X);
            y_q   <= Y_W'(START_Y);
            room  <= ROOM_W'(START_ROOM);
            sword <= 1'b0;
            slain <= 1'b0;
            moves <= '0;
            win   <= 1'b0;
            d     <= 1'b0;
        end else if (accept) begin
            x_q   <= cand_x;
            y_q   <= cand_y;
            room  <= cand_room;
            moves <= moves_inc;
            if (at_sword) sword <= 1'b1;
            slain <= slain_next;
            // Dragon death outranks a win, which outranks the move limit
            if (dragon_kills) begin
                state <= DEAD;
                d     <= 1'b1;
            end else if (wins) begin
                state <= WIN;
                win   <= 1'b1;
            end else if (limit_hit) begin
                state <= DEAD;
                d     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grid_game_fsm.sv
// Directed bench for grid_game_fsm on the default 3x3 map plus a blocked-room variant.
`timescale 1ns/1ps
module tb_grid_game_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
    logic [3:0] room, room_b;
    logic       sword, slain, win, d;
    logic       sword_b, slain_b, win_b, d_b;
    logic [3:0] moves, moves_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grid_game_fsm dut (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(room), .sword(sword), .slain(slain), .moves(moves), .win(win), .d(d)
    );

    grid_game_fsm #(.BLOCK_MASK(9'b000000010)) dut_blk (
        .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
        .room(room_b), .sword(sword_b), .slain(slain_b), .moves(moves_b), .win(win_b), .d(d_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply a direction vector {n,s,e,w} for exactly one rising edge
    task automatic pulse(input logic [3:0] dir);
        @(negedge clk);
        {n, s, e, w} = dir;
        @(posedge clk);
        #1;
        {n, s, e, w} = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    localparam logic [3:0] N = 4'b1000, S = 4'b0100, E = 4'b0010, W = 4'b0001;

    initial begin
        do_reset();
        check("rst_room", room, 0);
        check("rst_sword", sword, 0);
        check("rst_moves", moves, 0);
        check("rst_win_d", {win, d, slain}, 0);

        // Full winning walk
        pulse(E); check("t1_room1", room, 1);
        pulse(E); check("t1_room2", room, 2); check("t1_sword", sword, 1);
        pulse(S); check("t1_room5", room, 5);
        pulse(W); check("t1_room4", room, 4); check("t1_slain", slain, 1); check("t1_d0_mid", d, 0);
        pulse(E); check("t1_room5b", room, 5); check("t1_nowin", win, 0);
        pulse(S); check("t1_room8", room, 8); check("t1_win", win, 1);
        check("t1_moves", moves, 6); check("t1_d", d, 0);
        pulse(N); check("t1_term_room", room, 8); check("t1_term_moves", moves, 6);

        // Dragon without sword
        do_reset();
        pulse(S); check("t2_room3", room, 3);
        pulse(E); check("t2_room4", room, 4); check("t2_d", d, 1); check("t2_sword", sword, 0);
        pulse(E); pulse(E);
        check("t2_stay_room", room, 4); check("t2_stay_moves", moves, 2); check("t2_nowin", win, 0);

        // Off-grid and multi-direction rejects
        do_reset();
        pulse(N); check("t3_n_room", room, 0); check("t3_n_moves", moves, 0);
        pulse(W); check("t3_w_room", room, 0); check("t3_w_moves", moves, 0);
        pulse(N | E); check("t3_ne_room", room, 0); check("t3_ne_moves", moves, 0);
        pulse(S | E); check("t3_se_room", room, 0);

        // Blocked room 1 on the variant instance
        do_reset();
        pulse(E); check("t4_blk_room", room_b, 0); check("t4_blk_moves", moves_b, 0);
        check("t4_free_room", room, 1);
        pulse(S); check("t4_blk_s_room", room_b, 3); check("t4_blk_s_moves", moves_b, 1);

        // Eight alternating moves: limit vs free counting
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pulse(E);
            pulse(W);
        end
        check("t5_room", room, 0);
        check("t5_moves", moves, 8);
`ifdef GAME_MOVE_LIMIT_EN
        check("t5_d", d, 1);
        pulse(E); check("t5_dead_room", room, 0); check("t5_dead_moves", moves, 8);
`else
        check("t5_d", d, 0);
        for (int i = 0; i < 4; i++) begin
            pulse(E);
            pulse(W);
        end
        check("t5_sat_moves", moves, 15);
        check("t5_sat_room", room, 0);
`endif

        // Asynchronous reset between edges
        do_reset();
        pulse(E); pulse(E); pulse(S);
        check("t6_pre_room", room, 5); check("t6_pre_sword", sword, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_room", room, 0);
        check("t6_async_sword", sword, 0);
        check("t6_async_moves", moves, 0);
        @(negedge clk);
        reset = 1'b1;
        pulse(E); check("t6_after_room", room, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
